// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sequencer sharing one combinational ALU between two requesters
// Optional illegal-opcode trapping is enabled by defining ALU_ARB_ILLEGAL_OP_EN.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [OPW-1:0]   req_op0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [OPW-1:0]   req_op1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [OPW-1:0]   op_code;
    logic             owner;
    logic             last_grant;
    logic             winner;
    logic             owner_ready;

    // On a tie the requester that did not finish last goes next.
    always_comb begin
        winner = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && req_valid != 2'b00) begin
            req_ready = winner ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        resp_valid = 2'b00;
        if (state == RESP) begin
            resp_valid = owner ? 2'b10 : 2'b01;
        end
    end

    assign owner_ready = owner ? resp_ready[1] : resp_ready[0];
    assign alu_a       = op_a;
    assign alu_b       = op_b;
    assign alu_op      = op_code;

`ifndef ALU_ARB_ILLEGAL_OP_EN
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            op_code     <= '0;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            resp_result <= '0;
            resp_zero   <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            resp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        owner   <= winner;
                        op_a    <= winner ? req_a1  : req_a0;
                        op_b    <= winner ? req_b1  : req_b0;
                        op_code <= winner ? req_op1 : req_op0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
                    if (op_code > OPW'(5)) begin
                        resp_result <= '0;
                        resp_zero   <= 1'b1;
                        resp_err    <= 1'b1;
                    end else begin
                        resp_result <= alu_result;
                        resp_zero   <= alu_zero;
                        resp_err    <= 1'b0;
                    end
`else
                    resp_result <= alu_result;
                    resp_zero   <= alu_zero;
`endif
                    state <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
